// File: rtl/data_mem_bridge_pkg.sv
// Shared types and constants for the core data-port to memory-bus bridge.
//   bridge_state_t : FSM encoding (IDLE, REQ, WAIT_R, DONE)
//   mask_*         : core size masks carried on data_write_byte
//   is_misaligned  : size/offset alignment rule
package data_mem_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_DONE   = 2'd3
  } bridge_state_t;

  localparam logic [3:0]  mask_byte = 4'b0001;
  localparam logic [3:0]  mask_half = 4'b0011;
  localparam logic [3:0]  mask_word = 4'b1111;

  localparam logic [31:0] ERR_READ_DATA_DEF = 32'hDEADBEEF;

  // Bytes are never misaligned; halves need addr[0]==0, words addr[1:0]==0.
  function automatic logic is_misaligned(input logic [3:0] mask, input logic [1:0] off);
    return ((mask == mask_half) && off[0]) || ((mask == mask_word) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/data_mem_bridge_lane_align.sv
// Byte-lane alignment between the right-aligned core view and the
// lane-positioned memory bus view.
//   wr_off_i/wdata_i/be_i -> wdata_o/be_o : store data and enables shifted up
//   rd_off_i/rdata_i      -> rdata_o      : load data shifted down to bit 0
module data_mem_bridge_lane_align (
  input  logic [1:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  be_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  be_o,
  input  logic [1:0]  rd_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    wdata_o = wdata_i << {wr_off_i, 3'b000};
    be_o    = be_i << wr_off_i;
    // Upper lanes are left as shifted in (zeros); extension is the core's job.
    rdata_o = rdata_i >> {rd_off_i, 3'b000};
  end

endmodule

// File: rtl/data_mem_bridge.sv
// Core data port -> word-addressed request/grant/response memory bus.
// Core side : data_read_valid, data_write_valid, data_addr, data_write,
//             data_write_byte in; data_read, data_ready out.
// Bus side  : mem_req, mem_we, mem_addr, mem_wdata, mem_be out;
//             mem_gnt, mem_rvalid, mem_rdata in.
// Status    : bus_error (sticky until reset), misaligned (1-cycle pulse).
// Each access: IDLE -> REQ -> WAIT_R -> DONE, or IDLE -> DONE when misaligned,
// with a per-access timeout covering REQ and WAIT_R.
module data_mem_bridge
  import data_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_READ_DATA  = ERR_READ_DATA_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_read_valid,
  input  logic        data_write_valid,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_write,
  input  logic [3:0]  data_write_byte,
  output logic [31:0] data_read,
  output logic        data_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_error,
  output logic        misaligned
);

  localparam int unsigned    CW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  bridge_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   data_read_q, data_read_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          berr_q, berr_d;
  logic          mis_q, mis_d;

  logic          req;
  logic          mis_req;
  logic          timeout;
  logic [31:0]   wdata_sh;
  logic [3:0]    be_sh;
  logic [31:0]   rdata_sh;

  assign req     = data_read_valid | data_write_valid;
  assign mis_req = is_misaligned(data_write_byte, data_addr[1:0]);
  assign timeout = (cnt_q == TO_LAST);

  // Write path aligns on the live address (latched on acceptance);
  // read path aligns on the offset captured with the request.
  data_mem_bridge_lane_align u_lane_align (
    .wr_off_i (data_addr[1:0]),
    .wdata_i  (data_write),
    .be_i     (data_write_byte),
    .wdata_o  (wdata_sh),
    .be_o     (be_sh),
    .rd_off_i (off_q),
    .rdata_i  (mem_rdata),
    .rdata_o  (rdata_sh)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    data_read_d = data_read_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    berr_d      = berr_q;
    mis_d       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (mis_req) begin
            mis_d   = 1'b1;
            berr_d  = 1'b1;
            if (!data_write_valid) data_read_d = ERR_READ_DATA;
            state_d = ST_DONE;
          end else begin
            addr_d  = {data_addr[31:2], 2'b00};
            we_d    = data_write_valid;   // store wins when both are requested
            off_d   = data_addr[1:0];
            wdata_d = wdata_sh;
            be_d    = be_sh;
            cnt_d   = '0;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_gnt) begin
          if (mem_rvalid) begin
            // grant and response in the same cycle: skip WAIT_R
            if (!we_q) data_read_d = rdata_sh;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_R;
          end
        end else if (timeout) begin
          berr_d  = 1'b1;
          if (!we_q) data_read_d = ERR_READ_DATA;
          state_d = ST_DONE;
        end
      end
      ST_WAIT_R: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_rvalid) begin
          if (!we_q) data_read_d = rdata_sh;
          state_d = ST_DONE;
        end else if (timeout) begin
          berr_d  = 1'b1;
          if (!we_q) data_read_d = ERR_READ_DATA;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      data_read_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      berr_q      <= 1'b0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      data_read_q <= data_read_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      berr_q      <= berr_d;
      mis_q       <= mis_d;
    end
  end

  // mem_req is a pure state decode, so a reset or timeout drops it on the
  // very next cycle without extra bookkeeping.
  assign mem_req    = (state_q == ST_REQ);
  assign data_ready = ((state_q == ST_IDLE) && !req) || (state_q == ST_DONE);
  assign data_read  = data_read_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_be     = be_q;
  assign bus_error  = berr_q;
  assign misaligned = mis_q;

endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_read_valid, data_write_valid;
  logic [31:0] data_addr, data_write;
  logic [3:0]  data_write_byte;
  logic [31:0] data_read;
  logic        data_ready;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_error, misaligned;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  data_mem_bridge #(.TIMEOUT_CYCLES(16), .ERR_READ_DATA(32'hDEADBEEF)) dut (
    .clk(clk), .reset(reset),
    .data_read_valid(data_read_valid), .data_write_valid(data_write_valid),
    .data_addr(data_addr), .data_write(data_write), .data_write_byte(data_write_byte),
    .data_read(data_read), .data_ready(data_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_error(bus_error), .misaligned(misaligned)
  );

  typedef struct {
    logic        we;     // drive data_write_valid
    logic        both;   // also drive data_read_valid
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  m;
    int          gdly;   // REQ cycles before grant (>=1000: never)
    int          rdly;   // cycles after grant before rvalid (0: same cycle)
    logic [31:0] rd;
    int          ereqc;  // cycles mem_req is high
    int          elowc;  // cycles data_ready is low
    logic [31:0] eaddr;
    logic [31:0] ewd;
    logic [3:0]  ebe;
    logic        ewe;
    logic [31:0] edr;
    logic        eberr;
    logic        emis;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_acc(input vec_t t, output int reqc, output int lowc,
                         output logic [31:0] oaddr, output logic [31:0] owd,
                         output logic [3:0] obe, output logic owe,
                         output logic mis, output logic done);
    int rq;
    int since;
    rq = 0; since = -1; reqc = 0; lowc = 0;
    oaddr = '0; owd = '0; obe = '0; owe = 1'b0; mis = 1'b0; done = 1'b0;
    @(negedge clk);
    data_write_valid = t.we;
    data_read_valid  = !t.we || t.both;
    data_addr        = t.addr;
    data_write       = t.wd;
    data_write_byte  = t.m;
    for (int c = 0; c < 200 && !done; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hFFFF0000;
      #1;
      if (misaligned) mis = 1'b1;
      if (mem_req) begin
        if (reqc == 0) begin
          oaddr = mem_addr; owd = mem_wdata; obe = mem_be; owe = mem_we;
        end
        if (rq == t.gdly) begin
          mem_gnt = 1'b1; since = 0;
          if (t.rdly == 0) begin mem_rvalid = 1'b1; mem_rdata = t.rd; end
        end
        rq++; reqc++;
      end else if (since >= 0) begin
        since++;
        if (since == t.rdly) begin mem_rvalid = 1'b1; mem_rdata = t.rd; end
      end
      if (data_ready) done = 1'b1;
      else lowc++;
      @(negedge clk);
    end
    data_read_valid = 1'b0; data_write_valid = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  vec_t v[11];

  initial begin
    int reqc, lowc;
    logic [31:0] oaddr, owd;
    logic [3:0]  obe;
    logic        owe, mis, done;
    vec_t        t;

    //        we both addr         wd            m     gdly  rdly  rd            reqc low eaddr        ewd           ebe    ewe  edr           berr mis
    v[0]  = '{0, 0, 32'h100, 32'h0,        4'hF, 0,    1,    32'h12345678, 1,  3,  32'h100, 32'h0,        4'hF, 0, 32'h12345678, 0, 0};
    v[1]  = '{1, 0, 32'h203, 32'h000000AB, 4'h1, 0,    1,    32'hFFFFFFFF, 1,  3,  32'h200, 32'hAB000000, 4'h8, 1, 32'h12345678, 0, 0};
    v[2]  = '{0, 0, 32'h302, 32'h0,        4'h3, 0,    1,    32'hBEEF1234, 1,  3,  32'h300, 32'h0,        4'hC, 0, 32'h0000BEEF, 0, 0};
    v[3]  = '{0, 0, 32'h201, 32'h0,        4'h1, 2,    0,    32'h11223344, 3,  4,  32'h200, 32'h0,        4'h2, 0, 32'h00112233, 0, 0};
    v[4]  = '{1, 1, 32'h102, 32'h0000CAFE, 4'h3, 0,    3,    32'h0,        1,  5,  32'h100, 32'hCAFE0000, 4'hC, 1, 32'h00112233, 0, 0};
    v[5]  = '{0, 0, 32'h401, 32'h0,        4'hF, 0,    1,    32'h0,        0,  1,  32'h0,   32'h0,        4'h0, 0, 32'hDEADBEEF, 1, 1};
    v[6]  = '{1, 0, 32'h0FF, 32'h00001234, 4'h3, 0,    1,    32'h0,        0,  1,  32'h0,   32'h0,        4'h0, 0, 32'hDEADBEEF, 1, 1};
    v[7]  = '{0, 0, 32'h500, 32'h0,        4'hF, 1,    2,    32'hA5A50F0F, 2,  5,  32'h500, 32'h0,        4'hF, 0, 32'hA5A50F0F, 1, 0};
    v[8]  = '{0, 0, 32'h600, 32'h0,        4'hF, 1000, 1,    32'h0,        16, 17, 32'h600, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1, 0};
    v[9]  = '{0, 0, 32'h700, 32'h0,        4'hF, 0,    1,    32'h0BADF00D, 1,  3,  32'h700, 32'h0,        4'hF, 0, 32'h0BADF00D, 1, 0};
    v[10] = '{0, 0, 32'h604, 32'h0,        4'hF, 0,    1000, 32'h0,        1,  17, 32'h604, 32'h0,        4'hF, 0, 32'hDEADBEEF, 1, 0};

    reset = 1'b1;
    data_read_valid = 1'b0; data_write_valid = 1'b0;
    data_addr = '0; data_write = '0; data_write_byte = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_data_read", data_read, 32'h0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'h0);
    chk("rst_bus_error", {31'b0, bus_error}, 32'h0);
    chk("rst_misaligned", {31'b0, misaligned}, 32'h0);
    chk("rst_data_ready", {31'b0, data_ready}, 32'h1);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      t = v[i];
      run_acc(t, reqc, lowc, oaddr, owd, obe, owe, mis, done);
      #1;
      chk($sformatf("v%0d_done", i), {31'b0, done}, 32'h1);
      chk($sformatf("v%0d_req_cycles", i), reqc, t.ereqc);
      chk($sformatf("v%0d_stall_cycles", i), lowc, t.elowc);
      chk($sformatf("v%0d_data_read", i), data_read, t.edr);
      chk($sformatf("v%0d_bus_error", i), {31'b0, bus_error}, {31'b0, t.eberr});
      chk($sformatf("v%0d_misaligned", i), {31'b0, mis}, {31'b0, t.emis});
      chk($sformatf("v%0d_mis_cleared", i), {31'b0, misaligned}, 32'h0);
      if (t.ereqc > 0) begin
        chk($sformatf("v%0d_mem_addr", i), oaddr, t.eaddr);
        chk($sformatf("v%0d_mem_wdata", i), owd, t.ewd);
        chk($sformatf("v%0d_mem_be", i), {28'b0, obe}, {28'b0, t.ebe});
        chk($sformatf("v%0d_mem_we", i), {31'b0, owe}, {31'b0, t.ewe});
      end
    end

    // Late response after a timeout must not touch data_read.
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'h13579BDF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("late_rvalid_data_read", data_read, 32'hDEADBEEF);
    chk("late_rvalid_idle_ready", {31'b0, data_ready}, 32'h1);
    chk("late_rvalid_no_req", {31'b0, mem_req}, 32'h0);

    // Reset while waiting for the response.
    @(negedge clk);
    data_read_valid = 1'b1; data_addr = 32'h900; data_write_byte = 4'hF;
    @(negedge clk);
    #1;
    chk("rstmid_in_req", {31'b0, mem_req}, 32'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    chk("rstmid_in_wait", {31'b0, mem_req}, 32'h0);
    chk("rstmid_wait_stall", {31'b0, data_ready}, 32'h0);
    reset = 1'b1; data_read_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("rstmid_mem_req", {31'b0, mem_req}, 32'h0);
    chk("rstmid_bus_error", {31'b0, bus_error}, 32'h0);
    chk("rstmid_data_read", data_read, 32'h0);
    chk("rstmid_ready", {31'b0, data_ready}, 32'h1);
    reset = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("rstmid_drop_resp", data_read, 32'h0);

    t = '{0, 0, 32'h800, 32'h0, 4'hF, 0, 1, 32'h55AA55AA, 1, 3, 32'h800, 32'h0, 4'hF, 0, 32'h55AA55AA, 0, 0};
    run_acc(t, reqc, lowc, oaddr, owd, obe, owe, mis, done);
    #1;
    chk("post_rst_done", {31'b0, done}, 32'h1);
    chk("post_rst_stall_cycles", lowc, 3);
    chk("post_rst_mem_addr", oaddr, 32'h800);
    chk("post_rst_data_read", data_read, 32'h55AA55AA);
    chk("post_rst_bus_error", {31'b0, bus_error}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
